mem_wb_stage: RTL and testbench

MEM_WB_STAGE -- requirements
Module: mem_wb_stage

---
 rtl/mem_wb_stage.sv | 150 +++++++++++++++
 tb/tb_mem_wb_stage.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_wb_stage.sv
`default_nettype none
// ============================================================================
// Module   : mem_wb_stage
// Purpose  : MEM and WB back end of a 16-bit pipeline. Holds the EX/MEM
//            and MEM/WB registers and a 256 x 16 data memory. It resolves
//            branches, forwards ALU results from the MEM stage, and drives
//            the register-file write port.
//            All state updates on the falling edge of clock.
// Ports    :
//   clock, reset                  falling-edge clock, async active-high reset
//   ex_regwrite/memtoreg/memwrite EX-stage control
//   ex_branch [1:0]               01 = BEQ, 10 = BNE, others = none
//   ex_zero                       EX ALU zero flag
//   ex_aluout [15:0]              ALU result, write data or byte address
//   ex_storedata [15:0]           store data (rt)
//   ex_wr [1:0]                   destination register
//   ex_target [15:0]              branch target
//   flush                         make the instruction captured this edge a bubble
//   branch_taken/branch_target    redirect request to fetch
//   mem_fwd_valid/wr/data         MEM-stage forwarding source
//   mem_load_busy                 MEM stage holds a load to a non-$0 register
//   wb_regwrite/wb_wr/wb_wd       register-file write port
// Revision : 1.0 - initial release
// ============================================================================
module mem_wb_stage (
    input  logic        clock,
    input  logic        reset,
    input  logic        ex_regwrite,
    input  logic        ex_memtoreg,
    input  logic        ex_memwrite,
    input  logic [1:0]  ex_branch,
    input  logic        ex_zero,
    input  logic [15:0] ex_aluout,
    input  logic [15:0] ex_storedata,
    input  logic [1:0]  ex_wr,
    input  logic [15:0] ex_target,
    input  logic        flush,
    output logic        branch_taken,
    output logic [15:0] branch_target,
    output logic        mem_fwd_valid,
    output logic [1:0]  mem_fwd_wr,
    output logic [15:0] mem_fwd_data,
    output logic        mem_load_busy,
    output logic        wb_regwrite,
    output logic [1:0]  wb_wr,
    output logic [15:0] wb_wd
);

    localparam logic [1:0] C_BR_BEQ = 2'b01;
    localparam logic [1:0] C_BR_BNE = 2'b10;
    localparam logic [1:0] C_REG_ZERO = 2'b00;

    // EX/MEM register
    logic        r_em_regwrite;
    logic        r_em_memtoreg;
    logic        r_em_memwrite;
    logic [1:0]  r_em_branch;
    logic        r_em_zero;
    logic [15:0] r_em_aluout;
    logic [15:0] r_em_storedata;
    logic [1:0]  r_em_wr;
    logic [15:0] r_em_target;

    // MEM/WB register
    logic        r_mw_regwrite;
    logic        r_mw_memtoreg;
    logic [1:0]  r_mw_wr;
    logic [15:0] r_mw_aluout;
    logic [15:0] r_mw_rdata;

    // Data memory, deliberately not reset so contents survive a reset.
    logic [15:0] r_dmem [0:255];
    logic [7:0]  w_word_addr;
    logic [15:0] w_rdata;

    // Byte address to word index; bit 0 and bits above 8 are ignored.
    assign w_word_addr = r_em_aluout[8:1];
    assign w_rdata     = r_dmem[w_word_addr];

    // Data fields are cleared too, because every output must read 0 during reset.
    always_ff @(negedge clock or posedge reset) begin
        if (reset) begin
            r_em_regwrite  <= 1'b0;
            r_em_memtoreg  <= 1'b0;
            r_em_memwrite  <= 1'b0;
            r_em_branch    <= 2'b00;
            r_em_zero      <= 1'b0;
            r_em_aluout    <= 16'h0000;
            r_em_storedata <= 16'h0000;
            r_em_wr        <= 2'b00;
            r_em_target    <= 16'h0000;
        end else begin
            // A flushed slot keeps its data fields. Every side effect is
            // disabled, and memtoreg is cleared so the slot cannot raise
            // load-busy.
            r_em_regwrite  <= ex_regwrite & ~flush;
            r_em_memtoreg  <= ex_memtoreg & ~flush;
            r_em_memwrite  <= ex_memwrite & ~flush;
            r_em_branch    <= flush ? 2'b00 : ex_branch;
            r_em_zero      <= ex_zero;
            r_em_aluout    <= ex_aluout;
            r_em_storedata <= ex_storedata;
            r_em_wr        <= ex_wr;
            r_em_target    <= ex_target;
        end
    end

    // The store commits at the edge that ends its MEM cycle. A load in the
    // next cycle therefore reads the new value combinationally. A pending
    // store is dropped on reset because r_em_memwrite clears asynchronously.
    always_ff @(negedge clock) begin
        if (r_em_memwrite) begin
            r_dmem[w_word_addr] <= r_em_storedata;
        end
    end

    always_ff @(negedge clock or posedge reset) begin
        if (reset) begin
            r_mw_regwrite <= 1'b0;
            r_mw_memtoreg <= 1'b0;
            r_mw_wr       <= 2'b00;
            r_mw_aluout   <= 16'h0000;
            r_mw_rdata    <= 16'h0000;
        end else begin
            r_mw_regwrite <= r_em_regwrite;
            r_mw_memtoreg <= r_em_memtoreg;
            r_mw_wr       <= r_em_wr;
            r_mw_aluout   <= r_em_aluout;
            r_mw_rdata    <= w_rdata;
        end
    end

    // Branch resolution in MEM
    assign branch_taken  = ((r_em_branch == C_BR_BEQ) &  r_em_zero) |
                           ((r_em_branch == C_BR_BNE) & ~r_em_zero);
    assign branch_target = r_em_target;

    // Forwarding and hazard information
    assign mem_fwd_valid = r_em_regwrite & ~r_em_memtoreg & (r_em_wr != C_REG_ZERO);
    assign mem_fwd_wr    = r_em_wr;
    assign mem_fwd_data  = r_em_aluout;
    assign mem_load_busy = r_em_memtoreg & r_em_regwrite & (r_em_wr != C_REG_ZERO);

    // Writeback; $0 is never written.
    assign wb_regwrite = r_mw_regwrite & (r_mw_wr != C_REG_ZERO);
    assign wb_wr       = r_mw_wr;
    assign wb_wd       = r_mw_memtoreg ? r_mw_rdata : r_mw_aluout;

endmodule
`default_nettype wire

// File: tb/tb_mem_wb_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_wb_stage
// Purpose  : Directed self-checking bench for mem_wb_stage.
//            Inputs change on the rising edge and outputs are sampled there,
//            midway between the falling edges where the DUT updates.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_wb_stage;

    logic        clock;
    logic        reset;
    logic        ex_regwrite;
    logic        ex_memtoreg;
    logic        ex_memwrite;
    logic [1:0]  ex_branch;
    logic        ex_zero;
    logic [15:0] ex_aluout;
    logic [15:0] ex_storedata;
    logic [1:0]  ex_wr;
    logic [15:0] ex_target;
    logic        flush;
    logic        branch_taken;
    logic [15:0] branch_target;
    logic        mem_fwd_valid;
    logic [1:0]  mem_fwd_wr;
    logic [15:0] mem_fwd_data;
    logic        mem_load_busy;
    logic        wb_regwrite;
    logic [1:0]  wb_wr;
    logic [15:0] wb_wd;

    int total;
    int bad;

    mem_wb_stage dut (
        .clock         (clock),
        .reset         (reset),
        .ex_regwrite   (ex_regwrite),
        .ex_memtoreg   (ex_memtoreg),
        .ex_memwrite   (ex_memwrite),
        .ex_branch     (ex_branch),
        .ex_zero       (ex_zero),
        .ex_aluout     (ex_aluout),
        .ex_storedata  (ex_storedata),
        .ex_wr         (ex_wr),
        .ex_target     (ex_target),
        .flush         (flush),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .mem_fwd_valid (mem_fwd_valid),
        .mem_fwd_wr    (mem_fwd_wr),
        .mem_fwd_data  (mem_fwd_data),
        .mem_load_busy (mem_load_busy),
        .wb_regwrite   (wb_regwrite),
        .wb_wr         (wb_wr),
        .wb_wd         (wb_wd)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Drive one EX-stage instruction.
    task automatic set_ex(input logic rw, input logic m2r, input logic mw,
                          input logic [1:0] br, input logic z,
                          input logic [15:0] alu, input logic [15:0] sd,
                          input logic [1:0] wr, input logic [15:0] tgt,
                          input logic fl);
        ex_regwrite  = rw;
        ex_memtoreg  = m2r;
        ex_memwrite  = mw;
        ex_branch    = br;
        ex_zero      = z;
        ex_aluout    = alu;
        ex_storedata = sd;
        ex_wr        = wr;
        ex_target    = tgt;
        flush        = fl;
    endtask

    task automatic bubble();
        set_ex(1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 16'h0, 16'h0, 2'b00, 16'h0, 1'b0);
    endtask

    // Advance one falling edge and return at the next rising edge.
    task automatic tick();
        @(negedge clock);
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        set_ex(1'b1, 1'b0, 1'b0, 2'b01, 1'b1, 16'h00AA, 16'h0, 2'b10, 16'h0033, 1'b0);
        tick();
        tick();
        total++;
        if ({branch_taken, branch_target, mem_fwd_valid, mem_fwd_wr, mem_fwd_data,
             mem_load_busy, wb_regwrite, wb_wr, wb_wd} !== 56'd0) begin
            bad++;
            $display("FAIL reset_outputs: got bt=%0b tgt=%h fv=%0b fwr=%0d fd=%h lb=%0b wbrw=%0b wbwr=%0d wd=%h, want all 0",
                     branch_taken, branch_target, mem_fwd_valid, mem_fwd_wr, mem_fwd_data,
                     mem_load_busy, wb_regwrite, wb_wr, wb_wd);
        end
        reset = 1'b0;
        bubble();
        tick();
        tick();
    endtask

    task automatic test_alu_wb();
        set_ex(1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 16'h0008, 16'h0, 2'd2, 16'h0, 1'b0);
        tick();
        total++;
        if ({mem_fwd_valid, mem_fwd_wr, mem_fwd_data, mem_load_busy} !== {1'b1, 2'd2, 16'h0008, 1'b0}) begin
            bad++;
            $display("FAIL alu_fwd: got v=%0b wr=%0d d=%h lb=%0b, want 1 2 0008 0",
                     mem_fwd_valid, mem_fwd_wr, mem_fwd_data, mem_load_busy);
        end
        bubble();
        tick();
        total++;
        if ({wb_regwrite, wb_wr, wb_wd} !== {1'b1, 2'd2, 16'h0008}) begin
            bad++;
            $display("FAIL alu_wb: got rw=%0b wr=%0d wd=%h, want 1 2 0008", wb_regwrite, wb_wr, wb_wd);
        end
    endtask

    task automatic test_store_load();
        set_ex(1'b0, 1'b0, 1'b1, 2'b00, 1'b0, 16'h0010, 16'h1234, 2'd0, 16'h0, 1'b0);
        tick();
        set_ex(1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 16'h0011, 16'h0, 2'd3, 16'h0, 1'b0);
        tick();
        total++;
        if ({mem_load_busy, mem_fwd_valid} !== 2'b10) begin
            bad++;
            $display("FAIL load_busy: got lb=%0b fv=%0b, want 1 0", mem_load_busy, mem_fwd_valid);
        end
        bubble();
        tick();
        total++;
        if ({wb_regwrite, wb_wr, wb_wd} !== {1'b1, 2'd3, 16'h1234}) begin
            bad++;
            $display("FAIL store_load_wb: got rw=%0b wr=%0d wd=%h, want 1 3 1234", wb_regwrite, wb_wr, wb_wd);
        end
    endtask

    task automatic test_branches();
        set_ex(1'b0, 1'b0, 1'b0, 2'b01, 1'b1, 16'h0, 16'h0, 2'd0, 16'h0040, 1'b0);
        tick();
        total++;
        if ({branch_taken, branch_target} !== {1'b1, 16'h0040}) begin
            bad++;
            $display("FAIL beq_taken: got bt=%0b tgt=%h, want 1 0040", branch_taken, branch_target);
        end
        set_ex(1'b0, 1'b0, 1'b0, 2'b10, 1'b1, 16'h0, 16'h0, 2'd0, 16'h0050, 1'b0);
        tick();
        total++;
        if (branch_taken !== 1'b0) begin
            bad++;
            $display("FAIL bne_not_taken: got bt=%0b, want 0", branch_taken);
        end
        set_ex(1'b0, 1'b0, 1'b0, 2'b10, 1'b0, 16'h0, 16'h0, 2'd0, 16'h0060, 1'b0);
        tick();
        total++;
        if ({branch_taken, branch_target} !== {1'b1, 16'h0060}) begin
            bad++;
            $display("FAIL bne_taken: got bt=%0b tgt=%h, want 1 0060", branch_taken, branch_target);
        end
        set_ex(1'b0, 1'b0, 1'b0, 2'b11, 1'b1, 16'h0, 16'h0, 2'd0, 16'h0070, 1'b0);
        tick();
        total++;
        if (branch_taken !== 1'b0) begin
            bad++;
            $display("FAIL branch_code11: got bt=%0b, want 0", branch_taken);
        end
        bubble();
    endtask

    task automatic test_flush();
        set_ex(1'b0, 1'b0, 1'b1, 2'b00, 1'b0, 16'h0020, 16'hAAAA, 2'd0, 16'h0, 1'b0);
        tick();
        set_ex(1'b1, 1'b0, 1'b1, 2'b01, 1'b1, 16'h0020, 16'h5555, 2'd1, 16'h0099, 1'b1);
        tick();
        total++;
        if ({mem_fwd_valid, branch_taken} !== 2'b00) begin
            bad++;
            $display("FAIL flush_mem: got fv=%0b bt=%0b, want 0 0", mem_fwd_valid, branch_taken);
        end
        set_ex(1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 16'h0020, 16'h0, 2'd2, 16'h0, 1'b0);
        tick();
        total++;
        if (wb_regwrite !== 1'b0) begin
            bad++;
            $display("FAIL flush_wb: got rw=%0b, want 0", wb_regwrite);
        end
        bubble();
        tick();
        total++;
        if ({wb_regwrite, wb_wr, wb_wd} !== {1'b1, 2'd2, 16'hAAAA}) begin
            bad++;
            $display("FAIL flush_mem_kept: got rw=%0b wr=%0d wd=%h, want 1 2 aaaa", wb_regwrite, wb_wr, wb_wd);
        end
    endtask

    task automatic test_zero_reg();
        set_ex(1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 16'hFFFF, 16'h0, 2'd0, 16'h0, 1'b0);
        tick();
        total++;
        if (mem_fwd_valid !== 1'b0) begin
            bad++;
            $display("FAIL r0_fwd: got fv=%0b, want 0", mem_fwd_valid);
        end
        bubble();
        tick();
        total++;
        if ({wb_regwrite, wb_wr, wb_wd} !== {1'b0, 2'd0, 16'hFFFF}) begin
            bad++;
            $display("FAIL r0_wb: got rw=%0b wr=%0d wd=%h, want 0 0 ffff", wb_regwrite, wb_wr, wb_wd);
        end
    endtask

    task automatic test_reset_mid();
        set_ex(1'b0, 1'b0, 1'b1, 2'b00, 1'b0, 16'h0030, 16'h1111, 2'd0, 16'h0, 1'b0);
        tick();
        // Store that also writes back; it is in EX/MEM when reset hits.
        set_ex(1'b1, 1'b0, 1'b1, 2'b01, 1'b1, 16'h0030, 16'h2222, 2'd1, 16'h0077, 1'b0);
        tick();
        total++;
        if ({mem_fwd_valid, branch_taken} !== 2'b11) begin
            bad++;
            $display("FAIL sw_rw_fwd: got fv=%0b bt=%0b, want 1 1", mem_fwd_valid, branch_taken);
        end
        bubble();
        reset = 1'b1;
        #1;
        total++;
        if ({branch_taken, branch_target, mem_fwd_valid, mem_fwd_wr, mem_fwd_data,
             mem_load_busy, wb_regwrite, wb_wr, wb_wd} !== 56'd0) begin
            bad++;
            $display("FAIL reset_mid_outputs: got bt=%0b tgt=%h fv=%0b fwr=%0d fd=%h lb=%0b wbrw=%0b wbwr=%0d wd=%h, want all 0",
                     branch_taken, branch_target, mem_fwd_valid, mem_fwd_wr, mem_fwd_data,
                     mem_load_busy, wb_regwrite, wb_wr, wb_wd);
        end
        tick();
        reset = 1'b0;
        set_ex(1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 16'h0030, 16'h0, 2'd1, 16'h0, 1'b0);
        tick();
        bubble();
        tick();
        total++;
        if ({wb_regwrite, wb_wr, wb_wd} !== {1'b1, 2'd1, 16'h1111}) begin
            bad++;
            $display("FAIL reset_mid_mem: got rw=%0b wr=%0d wd=%h, want 1 1 1111", wb_regwrite, wb_wr, wb_wd);
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        reset = 1'b1;
        bubble();
        @(posedge clock);
        #1;
        test_reset();
        test_alu_wb();
        test_store_load();
        test_branches();
        test_flush();
        test_zero_reg();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
